capture_readout: RTL and testbench
==================================

CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, capture-memory address width (4096 samples).
REQ-002 SHALL have parameter DATA_W, default 8, sample width.
REQ-003 SHALL have port in_clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port in_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_start  input  1  one-cycle request to begin a readout.
REQ-006 SHALL have port in_start_addr  input  ADDR_W  first address to read (oldest sample).
REQ-007 SHALL have port in_count  input  ADDR_W+1  number of samples to read, 0..4096.
REQ-008 SHALL have port out_mem_addr  output  ADDR_W  read address to capture memory.
REQ-009 SHALL have port in_mem_data  input  DATA_W  capture-memory read data.
REQ-010 SHALL have port out_data  output  DATA_W  stream byte.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port in_ready  input  1  downstream accepts out_data this cycle.
REQ-013 SHALL have port out_busy  output  1  readout in progress.
REQ-014 SHALL have port out_done  output  1  one-cycle pulse at end of readout.

Function
REQ-015 SHALL sample in_start_addr and in_count only on the cycle in_start=1 while in IDLE; in_start while busy SHALL be ignored.
REQ-016 SHALL clamp in_count above 4096 to 4096.
REQ-017 SHALL treat in_count=0 as empty: no beats; out_done pulses the cycle after start.
REQ-018 SHALL implement states IDLE -> ADDR -> WAIT -> SEND -> (ADDR if remaining>0, else FIN) -> IDLE; FIN lasts one cycle and asserts out_done.
REQ-019 Memory timing: in_mem_data is valid one cycle after out_mem_addr is presented, provided out_mem_addr is held unchanged; out_mem_addr SHALL be stable through ADDR and WAIT.
REQ-020 SHALL register in_mem_data into out_data at the end of WAIT; out_valid=1 throughout SEND.
REQ-021 out_data SHALL be stable while out_valid=1 and in_ready=0; a beat transfers on the cycle both are 1.
REQ-022 Address SHALL increment by 1 after each transfer, wrapping 4095 -> 0 (modulo 2^ADDR_W).
REQ-023 Throughput: at most one beat per 3 cycles with in_ready held high.
REQ-024 out_busy SHALL be 1 in every state except IDLE.
REQ-025 out_mem_addr SHALL hold its last value in IDLE; the module never writes the memory.

Reset
REQ-026 On in_clk with in_rst_n=0: state IDLE, out_valid=0, out_done=0, out_busy=0, out_data=0, out_mem_addr=0, remaining count=0.
REQ-027 Reset mid-readout SHALL abandon the transfer with no out_done pulse; the next readout starts cleanly from a new in_start.

Configuration
REQ-028 Macro CAPTURE_READOUT_CHECKSUM_EN defined: after the last sample beat, SEND SHALL emit one extra beat equal to the XOR of all sent samples (0x00 for count 0), then go to FIN; the accumulator clears on each accepted in_start.
REQ-029 Macro undefined: no checksum beat, no accumulator logic.

Structure
REQ-030 Package dla_pkg SHALL hold the state encoding (IDLE, ADDR, WAIT, SEND, FIN) and constants ADDR_W=12, DATA_W=8, MAX_COUNT=4096.
REQ-031 No sub-module; the FSM, address counter, remaining counter and checksum are implemented inline.

Verification
REQ-032 Memory preloaded with mem[a]=a[7:0]; start_addr=0x010, count=4, ready=1 -> beats 0x10,0x11,0x12,0x13; out_done once; busy low after.
REQ-033 start_addr=0xFFE, count=4 -> addresses 0xFFE,0xFFF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
REQ-034 count=3, in_ready low 5 cycles on the second beat -> out_data held at its value; no beat lost or duplicated.
REQ-035 count=0 -> zero beats, out_done the cycle after start; count=5000 -> exactly 4096 beats.
REQ-036 in_rst_n low for 1 cycle during the 2nd beat of count=8 -> out_valid=0 next cycle, no out_done; a subsequent start with count=2 completes normally.
REQ-037 CHECKSUM_EN, samples 0x10..0x13 -> fifth beat 0x00; samples 0x01,0x02,0x04 -> fourth beat 0x07.

Source files
------------

// File: rtl/dla_pkg.sv
// dla_pkg: state encoding and default sizes shared by the capture readout logic.
package dla_pkg;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam int MAX_COUNT = 4096;
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, FIN} state_t;
endpackage

// File: rtl/capture_readout.sv
// capture_readout: streams a window of capture memory out as a ready/valid byte stream.
// Define CAPTURE_READOUT_CHECKSUM_EN to append an XOR checksum beat after the samples.
module capture_readout #(
    parameter int ADDR_W = dla_pkg::ADDR_W,
    parameter int DATA_W = dla_pkg::DATA_W
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_start,
    input  logic [ADDR_W-1:0] in_start_addr,
    input  logic [ADDR_W:0]   in_count,
    output logic [ADDR_W-1:0] out_mem_addr,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              in_ready,
    output logic              out_busy,
    output logic              out_done
);
    import dla_pkg::state_t, dla_pkg::IDLE, dla_pkg::ADDR, dla_pkg::WAIT, dla_pkg::SEND, dla_pkg::FIN;

    localparam logic [ADDR_W:0] MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining, cnt_c;
    logic              accept, xfer, chk_phase;

    assign cnt_c        = (in_count > MAX) ? MAX : in_count;
    assign accept       = (state == IDLE) && in_start;
    assign xfer         = (state == SEND) && in_ready;
    assign out_mem_addr = addr;
    assign out_valid    = state == SEND;
    assign out_busy     = state != IDLE;
    assign out_done     = state == FIN;

`ifdef CAPTURE_READOUT_CHECKSUM_EN
    localparam state_t TAIL = SEND;
    logic [DATA_W-1:0] chk;
    logic              chk_beat;
    assign chk_phase = chk_beat;
`else
    localparam state_t TAIL = FIN;
    assign chk_phase = 1'b0;
`endif

    always_ff @(posedge in_clk)
        state <= !in_rst_n ? IDLE : next;

    // After the last sample, TAIL is either the checksum beat or FIN
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (in_start) next = (cnt_c == '0) ? TAIL : ADDR;
            ADDR:    next = WAIT;
            WAIT:    next = SEND;
            SEND:    if (in_ready) next = chk_phase ? FIN : (remaining > 1) ? ADDR : TAIL;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            addr      <= '0;
            remaining <= '0;
            out_data  <= '0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            chk       <= '0;
            chk_beat  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr      <= in_start_addr;
                remaining <= cnt_c;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                chk      <= '0;
                chk_beat <= cnt_c == '0;
                if (cnt_c == '0) out_data <= '0;
`endif
            end
            if (state == WAIT) out_data <= in_mem_data;
            if (xfer && !chk_phase) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                chk <= chk ^ out_data;
                if (remaining == 1) begin
                    out_data <= chk ^ out_data;
                    chk_beat <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: directed checks of capture_readout against a preloaded memory.
module tb_capture_readout;
    logic        clk = 0, rst_n = 0, start = 0, in_ready = 1;
    logic [11:0] start_addr = '0, mem_addr;
    logic [12:0] count = '0;
    logic [7:0]  mem_data, out_data;
    logic        out_valid, out_busy, out_done;
    logic [7:0]  mem [4096];
    logic [7:0]  got_d[$];
    logic [11:0] got_a[$];
    int          vectors = 0, miscompares = 0, done_cnt, done_cyc, held_bad, nb;
    logic        post_busy;

    capture_readout dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_start_addr(start_addr),
        .in_count(count), .out_mem_addr(mem_addr), .in_mem_data(mem_data),
        .out_data(out_data), .out_valid(out_valid), .in_ready(in_ready),
        .out_busy(out_busy), .out_done(out_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [11:0] sa, input logic [12:0] cnt, input int stall_beat, input int stall_len);
        int left = stall_len;
        bit fin = 0;
        @(negedge clk);
        start = 1; start_addr = sa; count = cnt; in_ready = 1;
        @(negedge clk);
        start = 0; got_d.delete(); got_a.delete(); done_cnt = 0; done_cyc = -1; held_bad = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (out_done) begin done_cnt++; done_cyc = c; fin = 1; end
            if (out_valid) begin
                if (got_d.size() == stall_beat && left > 0) begin
                    in_ready = 0; left--;
                    if (out_data !== 8'(sa + 12'(stall_beat))) held_bad++;
                end else begin
                    in_ready = 1; got_d.push_back(out_data); got_a.push_back(mem_addr);
                end
            end
        end
        chk("done_within_budget", 32'(fin), 1);
        in_ready = 1;
        @(negedge clk);
        post_busy = out_busy;
        if (out_done) done_cnt++;
    endtask

    task automatic check_stream(input string tag, input logic [11:0] sa, input int n);
        int exp_n = n > 4096 ? 4096 : n;
        int bad = 0;
        logic [7:0] x = '0;
        int extra = 0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        extra = 1;
`endif
        chk({tag, "_beats"}, 32'(got_d.size()), 32'(exp_n + extra));
        for (int i = 0; i < exp_n; i++) begin
            logic [11:0] a = sa + 12'(i);
            if (i >= got_d.size() || got_d[i] !== a[7:0] || got_a[i] !== a) bad++;
            x ^= a[7:0];
        end
        chk({tag, "_data"}, 32'(bad), 0);
        if (extra == 1 && got_d.size() > exp_n) chk({tag, "_csum"}, 32'(got_d[exp_n]), 32'(x));
        chk({tag, "_done"}, 32'(done_cnt), 1);
        chk({tag, "_busy_after"}, 32'(post_busy), 0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(out_busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(out_done), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        rst_n = 1;

        run(12'h010, 13'd4, -1, 0);
        check_stream("basic", 12'h010, 4);
        chk("basic_b0", 32'(got_d[0]), 32'h10);
        chk("basic_b3", 32'(got_d[3]), 32'h13);

        run(12'hFFE, 13'd4, -1, 0);
        check_stream("wrap", 12'hFFE, 4);
        chk("wrap_a2", 32'(got_a[2]), 32'h000);
        chk("wrap_d1", 32'(got_d[1]), 32'hFF);

        run(12'h020, 13'd3, 1, 5);
        check_stream("stall", 12'h020, 3);
        chk("stall_held", 32'(held_bad), 0);
        chk("stall_b1", 32'(got_d[1]), 32'h21);

        run(12'h123, 13'd0, -1, 0);
        check_stream("empty", 12'h123, 0);
`ifndef CAPTURE_READOUT_CHECKSUM_EN
        chk("empty_done_cycle", 32'(done_cyc), 0);
`endif

        run(12'h100, 13'd5000, -1, 0);
        check_stream("clamp", 12'h100, 5000);
        chk("clamp_last", 32'(got_d[4095]), 32'hFF);

        @(negedge clk);
        start = 1; start_addr = 12'h040; count = 13'd8;
        @(negedge clk);
        start = 0; nb = 0;
        for (int c = 0; c < 100 && nb < 2; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) nb++;
        end
        chk("rst_mid_reached_beat2", 32'(nb), 2);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_busy", 32'(out_busy), 0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_done) done_cnt++;
        end
        chk("rst_mid_no_done", 32'(done_cnt), 0);
        run(12'h050, 13'd2, -1, 0);
        check_stream("after_rst", 12'h050, 2);

`ifdef CAPTURE_READOUT_CHECKSUM_EN
        mem[12'h200] = 8'h01; mem[12'h201] = 8'h02; mem[12'h202] = 8'h04;
        run(12'h200, 13'd3, -1, 0);
        chk("csum_beats", 32'(got_d.size()), 4);
        chk("csum_b2", 32'(got_d[2]), 32'h04);
        chk("csum_value", 32'(got_d[3]), 32'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
